// File: rtl/mem_lsu_if.sv
// ============================================================================
// Module      : mem_lsu_if
// Description : Data-memory port between the load/store sequencer and a
//               16-bit wide, byte-addressable memory. The memory reads
//               combinationally from mem_addr and writes on the rising edge.
//               master : sequencer side (drives enable/write/address/data)
//               slave  : memory side (returns read data)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_lsu_if #(
    parameter int ADDR_WIDTH = 16
);
    logic                  mem_en;
    logic                  mem_wr;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [15:0]           mem_wdata;
    logic [15:0]           mem_rdata;

    modport master (
        output mem_en,
        output mem_wr,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata
    );

    modport slave (
        input  mem_en,
        input  mem_wr,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata
    );
endinterface

`default_nettype wire

// File: rtl/mem_lsu.sv
// ============================================================================
// Module      : mem_lsu
// Description : Load/store sequencer. Turns byte/word load/store requests
//               into aligned 16-bit memory accesses: read-modify-write for
//               byte stores, two-access split for unaligned word accesses.
//               Big-endian: even byte -> bits [15:8], odd byte -> bits [7:0].
// Ports       : clk, rst          - clock, synchronous active-high reset
//               req, req_wr, req_byte, req_addr, req_wdata - request in
//               busy, done, rdata, err                     - status / result
//               mem (mem_lsu_if.master)                    - memory port
// Config      : MEM_LSU_UNALIGNED_EN - when defined, unaligned word accesses
//               are split; otherwise they complete at once with err=1.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_lsu #(
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req,
    input  logic                  req_wr,
    input  logic                  req_byte,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [15:0]           req_wdata,
    output logic                  busy,
    output logic                  done,
    output logic [15:0]           rdata,
    output logic                  err,
    mem_lsu_if.master             mem
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD0  = 3'd1,
        S_WR0  = 3'd2,
        S_RD1  = 3'd3,
        S_WR1  = 3'd4,
        S_DONE = 3'd5
    } state_t;

`ifdef MEM_LSU_UNALIGNED_EN
    localparam int c_WDATA_W = 16;
`else
    // Only the byte-store path reads the captured data back later.
    localparam int c_WDATA_W = 8;
`endif

    state_t                 r_state;
    logic [ADDR_WIDTH-1:0]  r_addr;
    logic                   r_wr;
    logic                   r_byte;
    logic [c_WDATA_W-1:0]   r_wdata;
    logic                   r_mem_en;
    logic                   r_mem_wr;
    logic [ADDR_WIDTH-1:0]  r_mem_addr;
    logic [15:0]            r_mem_wdata;

    logic [ADDR_WIDTH-1:0]  w_req_word;
    logic [ADDR_WIDTH-1:0]  w_addr0;
    logic                   w_req_err;
    logic [7:0]             w_sel_byte;
    logic [15:0]            w_rmw0;

    assign w_req_word = {req_addr[ADDR_WIDTH-1:1], 1'b0};
    assign w_addr0    = {r_addr[ADDR_WIDTH-1:1], 1'b0};
    assign w_sel_byte = r_addr[0] ? mem.mem_rdata[7:0] : mem.mem_rdata[15:8];

`ifdef MEM_LSU_UNALIGNED_EN
    logic                   w_unal;
    logic [ADDR_WIDTH-1:0]  w_addr1;
    logic [7:0]             r_hold;     // first-half byte of an unaligned load

    assign w_req_err = 1'b0;
    assign w_unal    = ~r_byte & r_addr[0];
    // Wraps modulo 2^ADDR_WIDTH, so 0xFFFF splits into 0xFFFE and 0x0000.
    assign w_addr1   = w_addr0 + ADDR_WIDTH'(2);

    // First write-back word: an unaligned word store puts its high byte into
    // the low half of the lower word; a byte store replaces the addressed byte.
    always_comb begin
        w_rmw0 = '0;
        if (w_unal)
            w_rmw0 = {mem.mem_rdata[15:8], r_wdata[15:8]};
        else if (r_addr[0])
            w_rmw0 = {mem.mem_rdata[15:8], r_wdata[7:0]};
        else
            w_rmw0 = {r_wdata[7:0], mem.mem_rdata[7:0]};
    end
`else
    assign w_req_err = ~req_byte & req_addr[0];

    always_comb begin
        w_rmw0 = '0;
        if (r_addr[0])
            w_rmw0 = {mem.mem_rdata[15:8], r_wdata[7:0]};
        else
            w_rmw0 = {r_wdata[7:0], mem.mem_rdata[7:0]};
    end
`endif

    // Memory-port outputs are registered, then forced to zero during reset so
    // that a pending write is dropped in the reset cycle.
    assign mem.mem_en    = r_mem_en & ~rst;
    assign mem.mem_wr    = r_mem_wr & ~rst;
    assign mem.mem_addr  = r_mem_addr & {ADDR_WIDTH{~rst}};
    assign mem.mem_wdata = r_mem_wdata & {16{~rst}};

    always_ff @(posedge clk) begin
        // A request arriving in IDLE is taken even when reset is asserted.
        if (rst && !(r_state == S_IDLE && req)) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_wr        <= 1'b0;
            r_byte      <= 1'b0;
            r_wdata     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            rdata       <= '0;
            r_mem_en    <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
`ifdef MEM_LSU_UNALIGNED_EN
            r_hold      <= '0;
`endif
        end else begin
            done        <= 1'b0;
            err         <= 1'b0;
            r_mem_en    <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            case (r_state)
                S_IDLE: begin
                    if (req) begin
                        r_addr  <= req_addr;
                        r_wr    <= req_wr;
                        r_byte  <= req_byte;
                        r_wdata <= req_wdata[c_WDATA_W-1:0];
                        busy    <= 1'b1;
                        if (w_req_err) begin
                            r_state <= S_DONE;
                            done    <= 1'b1;
                            err     <= 1'b1;
                            rdata   <= '0;
                        end else if (req_wr && !req_byte && !req_addr[0]) begin
                            r_state     <= S_WR0;
                            r_mem_en    <= 1'b1;
                            r_mem_wr    <= 1'b1;
                            r_mem_addr  <= w_req_word;
                            r_mem_wdata <= req_wdata;
                        end else begin
                            r_state    <= S_RD0;
                            r_mem_en   <= 1'b1;
                            r_mem_addr <= w_req_word;
                        end
                    end
                end
                S_RD0: begin
                    if (r_wr) begin
                        r_state     <= S_WR0;
                        r_mem_en    <= 1'b1;
                        r_mem_wr    <= 1'b1;
                        r_mem_addr  <= w_addr0;
                        r_mem_wdata <= w_rmw0;
                    end
`ifdef MEM_LSU_UNALIGNED_EN
                    else if (w_unal) begin
                        r_hold     <= mem.mem_rdata[7:0];
                        r_state    <= S_RD1;
                        r_mem_en   <= 1'b1;
                        r_mem_addr <= w_addr1;
                    end
`endif
                    else begin
                        r_state <= S_DONE;
                        done    <= 1'b1;
                        rdata   <= r_byte ? {8'h00, w_sel_byte} : mem.mem_rdata;
                    end
                end
                S_WR0: begin
`ifdef MEM_LSU_UNALIGNED_EN
                    if (w_unal) begin
                        r_state    <= S_RD1;
                        r_mem_en   <= 1'b1;
                        r_mem_addr <= w_addr1;
                    end else
`endif
                    begin
                        r_state <= S_DONE;
                        done    <= 1'b1;
                    end
                end
`ifdef MEM_LSU_UNALIGNED_EN
                S_RD1: begin
                    if (r_wr) begin
                        r_state     <= S_WR1;
                        r_mem_en    <= 1'b1;
                        r_mem_wr    <= 1'b1;
                        r_mem_addr  <= w_addr1;
                        r_mem_wdata <= {r_wdata[7:0], mem.mem_rdata[7:0]};
                    end else begin
                        r_state <= S_DONE;
                        done    <= 1'b1;
                        rdata   <= {r_hold, mem.mem_rdata[15:8]};
                    end
                end
                S_WR1: begin
                    r_state <= S_DONE;
                    done    <= 1'b1;
                end
`endif
                default: begin
                    // S_DONE and any unused encoding return to IDLE.
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_lsu.sv
// ============================================================================
// Module      : tb_mem_lsu
// Description : Directed self-checking bench for mem_lsu with a 64 KiB
//               behavioural memory (combinational read, clocked write).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        req_wr;
    logic        req_byte;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        busy;
    logic        done;
    logic [15:0] rdata;
    logic        err;

    mem_lsu_if #(.ADDR_WIDTH(16)) bus ();

    mem_lsu #(.ADDR_WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_wr    (req_wr),
        .req_byte  (req_byte),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .busy      (busy),
        .done      (done),
        .rdata     (rdata),
        .err       (err),
        .mem       (bus)
    );

    always #5 clk = ~clk;

    // Behavioural memory; the pre_* port lets the bench preload words.
    logic [15:0] mem [0:32767];
    logic        pre_en;
    logic [14:0] pre_idx;
    logic [15:0] pre_val;

    always @(posedge clk) begin
        if (pre_en)
            mem[pre_idx] <= pre_val;
        else if (bus.mem_en && bus.mem_wr)
            mem[bus.mem_addr[15:1]] <= bus.mem_wdata;
    end

    assign bus.mem_rdata = mem[bus.mem_addr[15:1]];

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic poke(input logic [15:0] byte_addr, input logic [15:0] val);
        @(negedge clk);
        pre_en  = 1'b1;
        pre_idx = byte_addr[15:1];
        pre_val = val;
        @(posedge clk);
        #1 pre_en = 1'b0;
    endtask

    // Issues one request and follows it to done (bounded). ncyc is the cycle
    // of done counted from the acceptance edge (0 if done never came).
    task automatic run_req(input logic wr, input logic byt, input logic [15:0] addr,
                           input logic [15:0] wdata, output int ncyc,
                           output logic [15:0] rd, output logic er, output int nen,
                           output int nwr, output logic w1, output logic b1);
        logic got;
        got = 1'b0; ncyc = 0; nen = 0; nwr = 0; rd = '0; er = 1'b0; w1 = 1'b0; b1 = 1'b0;
        @(negedge clk);
        req = 1'b1; req_wr = wr; req_byte = byt; req_addr = addr; req_wdata = wdata;
        @(posedge clk);
        #1 req = 1'b0;
        for (int n = 1; n <= 12 && !got; n++) begin
            if (n == 1) begin
                w1 = bus.mem_wr;
                b1 = busy;
            end
            if (bus.mem_en) nen++;
            if (bus.mem_en && bus.mem_wr) nwr++;
            if (done) begin
                got = 1'b1; ncyc = n; rd = rdata; er = err;
            end else begin
                @(posedge clk);
                #1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    int          ncyc, nen, nwr;
    logic [15:0] rd;
    logic        er, w1, b1;

    initial begin
        rst = 1'b1; req = 1'b0; req_wr = 1'b0; req_byte = 1'b0;
        req_addr = '0; req_wdata = '0; pre_en = 1'b0; pre_idx = '0; pre_val = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_rdata", rdata, 0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;
        check("idle_mem_en", bus.mem_en, 0);
        check("idle_mem_wr", bus.mem_wr, 0);
        check("idle_mem_addr", bus.mem_addr, 0);
        check("idle_mem_wdata", bus.mem_wdata, 0);

        // Aligned word store then load.
        run_req(1'b1, 1'b0, 16'h0010, 16'hBEEF, ncyc, rd, er, nen, nwr, w1, b1);
        check("wst_cyc", ncyc, 2);
        check("wst_busy1", b1, 1);
        check("wst_nen", nen, 1);
        check("wst_nwr", nwr, 1);
        check("wst_err", er, 0);
        check("wst_mem", mem[15'h0008], 16'hBEEF);
        check("wst_busy_after", busy, 0);
        run_req(1'b0, 1'b0, 16'h0010, 16'h0000, ncyc, rd, er, nen, nwr, w1, b1);
        check("wld_cyc", ncyc, 2);
        check("wld_rdata", rd, 16'hBEEF);
        check("wld_nen", nen, 1);
        check("wld_nwr", nwr, 0);
        check("wld_hold", rdata, 16'hBEEF);

        // Byte store (read-modify-write), then byte loads.
        poke(16'h0020, 16'h1234);
        run_req(1'b1, 1'b1, 16'h0021, 16'h00AB, ncyc, rd, er, nen, nwr, w1, b1);
        check("bst_cyc", ncyc, 3);
        check("bst_rd_cycle_wr", w1, 0);
        check("bst_nen", nen, 2);
        check("bst_nwr", nwr, 1);
        check("bst_mem", mem[15'h0010], 16'h12AB);
        run_req(1'b0, 1'b1, 16'h0020, 16'h0000, ncyc, rd, er, nen, nwr, w1, b1);
        check("bld_even_cyc", ncyc, 2);
        check("bld_even_rdata", rd, 16'h0012);
        run_req(1'b0, 1'b1, 16'h0021, 16'h0000, ncyc, rd, er, nen, nwr, w1, b1);
        check("bld_odd_rdata", rd, 16'h00AB);
        run_req(1'b1, 1'b1, 16'h0020, 16'h00CD, ncyc, rd, er, nen, nwr, w1, b1);
        check("bst_even_mem", mem[15'h0010], 16'hCDAB);

`ifdef MEM_LSU_UNALIGNED_EN
        poke(16'h0030, 16'h11AA);
        poke(16'h0032, 16'hBB22);
        run_req(1'b0, 1'b0, 16'h0031, 16'h0000, ncyc, rd, er, nen, nwr, w1, b1);
        check("uld_cyc", ncyc, 3);
        check("uld_rdata", rd, 16'hAABB);
        check("uld_nen", nen, 2);
        check("uld_err", er, 0);
        poke(16'h0000, 16'h5566);
        poke(16'hFFFE, 16'h7788);
        run_req(1'b1, 1'b0, 16'hFFFF, 16'hC0DE, ncyc, rd, er, nen, nwr, w1, b1);
        check("ust_cyc", ncyc, 5);
        check("ust_nwr", nwr, 2);
        check("ust_hi_word", mem[15'h7FFF], 16'h77C0);
        check("ust_lo_word", mem[15'h0000], 16'hDE66);
`else
        run_req(1'b0, 1'b0, 16'h0031, 16'h0000, ncyc, rd, er, nen, nwr, w1, b1);
        check("uerr_cyc", ncyc, 1);
        check("uerr_err", er, 1);
        check("uerr_rdata", rd, 16'h0000);
        check("uerr_nen", nen, 0);
        poke(16'h0030, 16'h4455);
        run_req(1'b1, 1'b0, 16'h0031, 16'hC0DE, ncyc, rd, er, nen, nwr, w1, b1);
        check("uerr_st_cyc", ncyc, 1);
        check("uerr_st_err", er, 1);
        check("uerr_st_mem", mem[15'h0018], 16'h4455);
`endif

        // Reset in the WR0 cycle of a byte store.
        poke(16'h0040, 16'h1234);
        @(negedge clk);
        req = 1'b1; req_wr = 1'b1; req_byte = 1'b1; req_addr = 16'h0041; req_wdata = 16'h0099;
        @(posedge clk);
        #1 req = 1'b0;
        @(posedge clk);
        #1;
        check("mid_in_wr0", bus.mem_wr, 1);
        rst = 1'b1;
        #1;
        check("mid_wr_gated", bus.mem_wr, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        check("mid_busy", busy, 0);
        check("mid_done", done, 0);
        @(posedge clk);
        #1;
        check("mid_done_later", done, 0);
        check("mid_mem", mem[15'h0020], 16'h1234);
        run_req(1'b0, 1'b1, 16'h0041, 16'h0000, ncyc, rd, er, nen, nwr, w1, b1);
        check("mid_next_cyc", ncyc, 2);
        check("mid_next_rdata", rd, 16'h0034);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/mem_lsu.md
# mem_lsu

Load/store sequencer that acts as the initiator on the byte-addressable, 16-bit-wide data memory port. It accepts byte and word load/store requests from the execute/memory stage and turns them into legal aligned word accesses with `enable`/`wr` semantics. The memory reads combinationally and writes on the rising edge, and never reads and writes in the same cycle. The sequencer performs read-modify-write for byte stores and splits unaligned word accesses into two aligned accesses. It sits between the pipeline's memory stage and the data memory instance and stalls the pipeline via `busy`.

## Interface
- `ADDR_WIDTH`, 16: byte-address width. Word index is `addr[ADDR_WIDTH-1:1]`.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `req` in 1: request valid; sampled only in IDLE.
- `req_wr` in 1: 1 = store, 0 = load.
- `req_byte` in 1: 1 = byte access, 0 = word access.
- `req_addr` in ADDR_WIDTH: byte address.
- `req_wdata` in 16: store data; byte stores use `[7:0]`.
- `busy` out 1: sequencer not in IDLE; pipeline must stall.
- `done` out 1: one-cycle completion pulse.
- `rdata` out 16: load result, valid while `done`=1, held until next `done`.
- `err` out 1: misaligned-access error, coincident with `done` (macro-dependent).
- `mem_en` out 1: memory enable.
- `mem_wr` out 1: memory write.
- `mem_addr` out ADDR_WIDTH: always even (`{addr[ADDR_WIDTH-1:1],1'b0}`).
- `mem_wdata` out 16: memory write data.
- `mem_rdata` in 16: memory read data, combinational from `mem_addr`.

## Operation
- Byte order is big-endian: the even byte address maps to word bits `[15:8]` and the odd byte address maps to bits `[7:0]`. Byte loads zero-extend.
- States and transitions:
  - IDLE → RD0 or WR0 when `req` is accepted. Addr, wr, byte and wdata are captured into registers.
  - RD0 → WR0 (read-modify-write), RD1 (unaligned load) or DONE.
  - WR0 → RD1 (unaligned store) or DONE.
  - RD1 → WR1 (store) or DONE.
  - WR1 → DONE.
  - DONE → IDLE.
- Sequences per request type:
  - Aligned word load: RD0 at the word address; `rdata` = `mem_rdata`.
  - Aligned word store: WR0 only; `mem_wdata` = `req_wdata`.
  - Byte load: RD0; the selected byte goes into `rdata[7:0]`, and `rdata[15:8]` = 0.
  - Byte store: RD0 captures the word, then WR0 writes it back with the addressed byte replaced by `req_wdata[7:0]`.
  - Unaligned word load at odd address A:
    - RD0 at word A-1; its bits `[7:0]` become `rdata[15:8]`.
    - RD1 at word A+1; its bits `[15:8]` become `rdata[7:0]`.
  - Unaligned word store at odd address A:
    - RD0 then WR0 on word A-1, replacing `[7:0]` with `wdata[15:8]`.
    - RD1 then WR1 on word A+1, replacing `[15:8]` with `wdata[7:0]`.
- Memory-port outputs per state:
  - RD states: `mem_en`=1, `mem_wr`=0; `mem_rdata` is captured at the end of the cycle.
  - WR states: `mem_en`=1, `mem_wr`=1.
  - IDLE and DONE: `mem_en`=0, `mem_wr`=0, `mem_addr`=0, `mem_wdata`=0.
- Address arithmetic is modulo 2^ADDR_WIDTH. For A=0xFFFF, the second word is at 0x0000.
- Memory-port outputs are gated with `~rst`, so no memory write occurs in a reset cycle.

## Timing
- Request handshake:
  - `req` is accepted in cycle 0 only when in IDLE; this acceptance is not blocked by `rst`.
  - The first memory operation is in cycle 1. `busy` is high from cycle 1 through the DONE cycle inclusive.
  - `req` is ignored while `busy`. A `req` held high is accepted in the cycle after DONE.
- Completion cycle (`done`) per request type:
  - Aligned word load or store: cycle 2.
  - Byte load: cycle 2.
  - Byte store: cycle 3.
  - Unaligned load: cycle 3.
  - Unaligned store: cycle 5.
- Reset values: state IDLE. `busy`, `done`, `err`, `mem_en` and `mem_wr` are 0. `rdata`, `mem_addr` and `mem_wdata` are 0.
- Reset mid-operation: the sequencer returns to IDLE on the next edge. No `done` is produced, and any write not yet clocked is dropped. Writes completed before reset stand.
- `err` is 0 for all legal accesses.

## Configuration
- Macro `MEM_LSU_UNALIGNED_EN`.
- Defined: unaligned word accesses are split as described above.
- Undefined: an unaligned word request goes IDLE → DONE with no memory access. `done`=1 and `err`=1 in cycle 1, and `rdata` = 0.
- Byte accesses are unaffected by the macro.

## Test plan
- Aligned word store then load: store 0xBEEF to 0x0010, then load 0x0010.
  - Store `done` in cycle 2.
  - Load `done` in cycle 2 with `rdata`=0xBEEF.
  - Exactly one memory cycle per access.
- Byte store: memory 0x0020 = 0x1234; store byte 0xAB to 0x0021.
  - Memory word becomes 0x12AB.
  - Byte load of 0x0020 returns 0x0012.
  - `mem_wr` is never high in the read cycle.
- Unaligned load (macro defined): word 0x0030 = 0x11AA and word 0x0032 = 0xBB22; load 0x0031.
  - `rdata`=0xAABB in cycle 3.
- Unaligned store with wrap (macro defined): 0x0000 = 0x5566 and 0xFFFE = 0x7788; store 0xC0DE to 0xFFFF.
  - 0xFFFE becomes 0x77C0 and 0x0000 becomes 0xDE66.
  - `done` in cycle 5.
- Macro undefined: load word at 0x0031.
  - `done`=1, `err`=1 and `rdata`=0 in cycle 1.
  - `mem_en` stays 0.
- Reset mid-op: assert `rst` in the WR0 cycle of a byte store to 0x0041 (word 0x0040 = 0x1234, `req_wdata[7:0]` = 0x99).
  - Word stays 0x1234.
  - No `done` is produced.
  - `busy`=0 after the edge.
  - The next request completes normally.
